// File: rtl/prefetch_filler_pkg.sv
// Shared types and constants for the prefetch filler: fetch state and counter sizing.
package prefetch_filler_pkg;

    typedef enum logic {
        PF_RUN   = 1'b0,
        PF_DRAIN = 1'b1
    } pf_state_t;

    function automatic int pf_ne_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int PF_NE_BITS = pf_ne_bits(3);

endpackage

// File: rtl/prefetch_filler_credit_counter.sv
// Up/down counter with synchronous load; load wins over inc/dec. Flags underflow.
module credit_counter
    import prefetch_filler_pkg::*;
#(
    parameter int W = PF_NE_BITS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && !dec) begin
            count <= count + W'(1);
        end else if (dec && !inc) begin
            count <= count - W'(1);
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(dec && !inc && !load && count == '0));

endmodule

// File: rtl/prefetch_filler.sv
// Producer side of the prefetch queue: issues sequential reads under a credit limit and
// pushes returned words, dropping stale responses after a redirect.
module prefetch_filler
    import prefetch_filler_pkg::*;
#(
    parameter  int DEPTH     = 3,
    parameter  int ADDR_BITS = 16,
    parameter  int DATA_BITS = 16,
    localparam int NE_BITS   = pf_ne_bits(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 redirect,
    input  logic [ADDR_BITS-1:0] redirect_addr,
    input  logic                 halt,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [ADDR_BITS-1:0] mem_req_addr,
    input  logic                 mem_resp_valid,
    input  logic [DATA_BITS-1:0] mem_resp_data,
    output logic                 fifo_add,
    output logic [DATA_BITS-1:0] fifo_new_entry,
    output logic                 fifo_clear,
    input  logic [NE_BITS-1:0]   fifo_num_entries,
    output logic [ADDR_BITS-1:0] pc
);

    pf_state_t          state, state_nxt;
    logic [NE_BITS-1:0] outstanding;
    logic [NE_BITS-1:0] stale;
    logic [NE_BITS-1:0] stale_load;
    logic [NE_BITS:0]   credit_sum;
    logic [NE_BITS:0]   inflight_sum;
    logic               fire;
    logic               resp_run;
    logic               resp_drain;

    // One extra bit so occupancy + outstanding can never wrap below DEPTH.
    assign credit_sum   = {1'b0, fifo_num_entries} + {1'b0, outstanding};
    assign inflight_sum = {1'b0, outstanding} + {1'b0, stale};

    assign mem_req_valid = !reset && (state == PF_RUN) && !halt && !redirect
                           && (credit_sum < (NE_BITS + 1)'(DEPTH));
    assign mem_req_addr  = pc;
    assign fire          = mem_req_valid && mem_req_ready;

    assign resp_run   = mem_resp_valid && (state == PF_RUN);
    assign resp_drain = mem_resp_valid && (state == PF_DRAIN);

    // A response landing with a redirect belongs to the abandoned stream; the queue is cleared next cycle anyway.
    assign fifo_add       = resp_run && !redirect && !reset;
    assign fifo_new_entry = mem_resp_data;

    always_comb begin
        stale_load = '0;
        if (state == PF_RUN) begin
            stale_load = outstanding + NE_BITS'(fire) - NE_BITS'(resp_run);
        end else begin
            stale_load = stale - NE_BITS'(resp_drain);
        end
    end

    credit_counter #(.W(NE_BITS)) u_outstanding (
        .clk      (clk),
        .reset    (reset),
        .inc      (fire),
        .dec      (resp_run),
        .load     (redirect),
        .load_val ('0),
        .count    (outstanding)
    );

    credit_counter #(.W(NE_BITS)) u_stale (
        .clk      (clk),
        .reset    (reset),
        .inc      (1'b0),
        .dec      (resp_drain),
        .load     (redirect),
        .load_val (stale_load),
        .count    (stale)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= PF_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (redirect) begin
            state_nxt = (stale_load != '0) ? PF_DRAIN : PF_RUN;
        end else if (state == PF_DRAIN) begin
            if (stale == '0 || (resp_drain && stale == NE_BITS'(1))) begin
                state_nxt = PF_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= '0;
            fifo_clear <= 1'b0;
        end else begin
            fifo_clear <= redirect;
            if (redirect) begin
                pc <= redirect_addr;
            end else if (fire) begin
                pc <= pc + ADDR_BITS'(1);
            end
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
        fifo_add |-> (fifo_num_entries != NE_BITS'(DEPTH)));

    a_no_unexpected_resp: assert property (@(posedge clk) disable iff (reset)
        mem_resp_valid |-> (inflight_sum != '0));

endmodule

// File: tb/tb_prefetch_filler.sv
// Directed bench for prefetch_filler with a memory/queue environment and an epoch-based reference model.
module tb_prefetch_filler;

    localparam int DEPTH   = 3;
    localparam int NE_BITS = $clog2(DEPTH + 1);

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        halt;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [15:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [15:0] mem_resp_data;
    logic        fifo_add;
    logic [15:0] fifo_new_entry;
    logic        fifo_clear;
    logic [NE_BITS-1:0] fifo_num_entries;
    logic [15:0] pc;

    always #5 clk = ~clk;

    prefetch_filler #(.DEPTH(DEPTH), .ADDR_BITS(16), .DATA_BITS(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .redirect         (redirect),
        .redirect_addr    (redirect_addr),
        .halt             (halt),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_addr     (mem_req_addr),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_data    (mem_resp_data),
        .fifo_add         (fifo_add),
        .fifo_new_entry   (fifo_new_entry),
        .fifo_clear       (fifo_clear),
        .fifo_num_entries (fifo_num_entries),
        .pc               (pc)
    );

    typedef struct {
        logic [15:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [15:0] fq[$];
    logic [15:0] req_log[$];
    logic [15:0] push_log[$];
    int          drops, clears, cyc, lat, errors, checks;
    logic        pop;
    logic [15:0] m_pc;
    int          m_epoch;
    logic        m_clear;

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ 16'hC0DE;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_env();
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mdata(mq[0].addr);
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = 16'h0000;
        end
        fifo_num_entries = NE_BITS'(fq.size());
    endtask

    // One clock: compare against the model at the falling edge, then advance environment and model.
    task automatic step();
        int          cur, old;
        logic        exp_valid, exp_add, resp, a_fire, a_add, a_clear;
        logic [15:0] a_addr, a_data, head_addr;
        @(negedge clk);
        cur = 0;
        old = 0;
        foreach (mq[i]) begin
            if (mq[i].epoch == m_epoch) cur++;
            else old++;
        end
        exp_valid = (old == 0) && !halt && !redirect && (fq.size() + cur < DEPTH);
        resp      = mem_resp_valid;
        exp_add   = 1'b0;
        head_addr = 16'h0000;
        if (resp) begin
            head_addr = mq[0].addr;
            exp_add   = (mq[0].epoch == m_epoch) && !redirect;
        end
        chk("mem_req_valid", mem_req_valid, exp_valid);
        if (exp_valid) chk("mem_req_addr", mem_req_addr, m_pc);
        chk("pc", pc, m_pc);
        chk("fifo_add", fifo_add, exp_add);
        if (exp_add) chk("fifo_new_entry", fifo_new_entry, mdata(head_addr));
        chk("fifo_clear", fifo_clear, m_clear);
        a_fire  = mem_req_valid && mem_req_ready;
        a_addr  = mem_req_addr;
        a_add   = fifo_add;
        a_data  = fifo_new_entry;
        a_clear = fifo_clear;
        @(posedge clk);
        #1;
        if (resp) begin
            if (!a_add) drops++;
            void'(mq.pop_front());
        end
        if (a_fire) begin
            mq.push_back('{a_addr, m_epoch, cyc + lat});
            req_log.push_back(a_addr);
        end
        if (a_clear) begin
            fq.delete();
            clears++;
        end else if (pop && fq.size() > 0) begin
            void'(fq.pop_front());
        end
        if (a_add) begin
            fq.push_back(a_data);
            push_log.push_back(a_data);
        end
        if (redirect) begin
            m_pc = redirect_addr;
            m_epoch++;
        end else if (exp_valid && mem_req_ready) begin
            m_pc = m_pc + 16'h0001;
        end
        m_clear = redirect;
        cyc++;
        drive_env();
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst mem_req_valid", mem_req_valid, 0);
        chk("rst fifo_add", fifo_add, 0);
        chk("rst fifo_clear", fifo_clear, 0);
        chk("rst pc", pc, 0);
        mq.delete();
        fq.delete();
        m_pc    = 16'h0000;
        m_clear = 1'b0;
        m_epoch++;
        drive_env();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d0, c0, p0;
        reset = 1'b0; redirect = 1'b0; redirect_addr = 16'h0000; halt = 1'b0;
        mem_req_ready = 1'b1; pop = 1'b0; lat = 1; cyc = 0; errors = 0; checks = 0;
        drops = 0; clears = 0; m_epoch = 0; m_pc = 16'h0000; m_clear = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_data = 16'h0000; fifo_num_entries = '0;
        do_reset();

        // 1: fill an empty queue back to back
        repeat (8) step();
        chk("t1 req count", req_log.size(), 3);
        if (req_log.size() >= 3) begin
            chk("t1 req0", req_log[0], 16'h0000);
            chk("t1 req1", req_log[1], 16'h0001);
            chk("t1 req2", req_log[2], 16'h0002);
        end
        chk("t1 queue size", fq.size(), 3);
        if (fq.size() == 3) begin
            chk("t1 q0", fq[0], 16'hC0DE);
            chk("t1 q1", fq[1], 16'hC0DF);
            chk("t1 q2", fq[2], 16'hC0DC);
        end
        chk("t1 valid while full", mem_req_valid, 0);

        // 2: each removal from a full queue buys exactly one request
        for (int k = 0; k < 2; k++) begin
            n = req_log.size();
            pop = 1'b1;
            step();
            pop = 1'b0;
            repeat (4) step();
            chk("t2 one req per pop", req_log.size(), n + 1);
            if (req_log.size() > n) chk("t2 req addr", req_log[n], 3 + k);
            chk("t2 queue full", fq.size(), 3);
        end

        // 3: redirect with two reads in flight
        do_reset();
        lat = 3;
        step();
        step();
        d0 = drops; c0 = clears; p0 = push_log.size();
        redirect = 1'b1; redirect_addr = 16'h0100;
        step();
        redirect = 1'b0;
        repeat (8) step();
        chk("t3 clear pulses", clears - c0, 1);
        chk("t3 drops", drops - d0, 2);
        chk("t3 pushed", push_log.size() > p0, 1);
        if (push_log.size() > p0) chk("t3 first push", push_log[p0], 16'hC1DE);

        // 4: redirect coinciding with a response and a ready memory
        do_reset();
        lat = 2;
        step();
        step();
        d0 = drops; n = req_log.size();
        redirect = 1'b1; redirect_addr = 16'h0200;
        step();
        redirect = 1'b0;
        chk("t4 no fire on redirect", req_log.size(), n);
        chk("t4 resp not pushed", drops - d0, 1);
        chk("t4 stale", dut.u_stale.count, 1);
        repeat (3) step();
        chk("t4 stale dropped", drops - d0, 2);
        if (req_log.size() > n) chk("t4 req redirect addr", req_log[n], 16'h0200);
        else chk("t4 req issued", req_log.size(), n + 1);

        // 5: address wrap, then halt
        do_reset();
        lat = 1;
        redirect = 1'b1; redirect_addr = 16'hFFFF;
        step();
        redirect = 1'b0;
        pop = 1'b1;
        n = req_log.size();
        repeat (4) step();
        pop = 1'b0;
        if (req_log.size() >= n + 2) begin
            chk("t5 req ffff", req_log[n], 16'hFFFF);
            chk("t5 req wrap", req_log[n + 1], 16'h0000);
        end else begin
            chk("t5 req count", req_log.size(), n + 2);
        end
        pop = 1'b1;
        repeat (3) step();
        pop = 1'b0;
        halt = 1'b1;
        step();
        n = req_log.size();
        repeat (3) step();
        chk("t5 halt blocks", req_log.size(), n);
        halt = 1'b0;
        step();

        // 6: asynchronous reset in the middle of a drain
        do_reset();
        lat = 4;
        step();
        step();
        redirect = 1'b1; redirect_addr = 16'h0300;
        step();
        redirect = 1'b0;
        chk("t6 stale", dut.u_stale.count, 2);
        chk("t6 draining no req", mem_req_valid, 0);
        chk("t6 clear high", fifo_clear, 1);
        do_reset();
        n = req_log.size();
        step();
        chk("t6 req after reset", req_log.size(), n + 1);
        if (req_log.size() > n) chk("t6 req addr", req_log[n], 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prefetch_filler.md
Name: prefetch_filler

Overview:
Producer-side engine for the FIFO prefetch queue. Issues sequential memory reads from an internal fetch PC and pushes returned words into the queue via its add/new_entry port. Reads the queue's num_entries for credit tracking, so it never overflows the queue. Sits between the memory interface and the instruction queue; the decoder consumes from the other end.

Parameters:
DEPTH, 3, depth of the downstream FIFO; also bounds outstanding reads
ADDR_BITS, 16, fetch address width, word-addressed
DATA_BITS, 16, memory word width, equal to the FIFO's BITS
NE_BITS, $clog2(DEPTH+1), width of occupancy/outstanding counters (localparam)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
redirect  in  1  one-cycle pulse: restart fetch at redirect_addr
redirect_addr  in  ADDR_BITS  new fetch address
halt  in  1  level: suppress new memory requests
mem_req_valid  out  1  read request valid
mem_req_ready  in  1  memory accepts request this cycle
mem_req_addr  out  ADDR_BITS  word address of request
mem_resp_valid  in  1  read data valid; responses return in order, 1+ cycles after acceptance
mem_resp_data  in  DATA_BITS  read data
fifo_add  out  1  push into queue
fifo_new_entry  out  DATA_BITS  pushed word, equal to mem_resp_data
fifo_clear  out  1  registered; ORed into queue reset by the integrator
fifo_num_entries  in  NE_BITS  queue occupancy
pc  out  ADDR_BITS  next address to request

Behaviour:
- Reset values: pc=0; outstanding=0; stale=0; state=RUN; fifo_clear=0; mem_req_valid=0; fifo_add=0.
- Request fire = mem_req_valid && mem_req_ready. On fire: pc <= pc+1, wrapping mod 2^ADDR_BITS; outstanding += 1.
- Credit rule: mem_req_valid = (state==RUN) && !halt && !redirect && (fifo_num_entries + outstanding < DEPTH). Sum is computed at NE_BITS+1 bits, so it cannot wrap. mem_req_addr = pc.
- Response in RUN: fifo_add = mem_resp_valid; fifo_new_entry = mem_resp_data combinationally, zero latency; outstanding -= 1.
- Simultaneous fire and response: outstanding is unchanged.
- Counter consistency: queue occupancy and outstanding update on the same edge, so the credit sum stays exact. Consumer removals only make the check conservative for one cycle.
- Redirect, any state:
  - pc <= redirect_addr.
  - fifo_clear pulses high for the next cycle.
  - stale <= outstanding + fire − (mem_resp_valid && state==RUN).
  - outstanding <= 0.
  - state <= DRAIN if the new stale is nonzero, else RUN.
  - No fire occurs in the redirect cycle, since mem_req_valid is masked.
- DRAIN:
  - mem_req_valid=0.
  - Each mem_resp_valid decrements stale; its data is dropped (fifo_add=0).
  - When stale reaches 0 → RUN.
  - A redirect in DRAIN reloads stale with the current stale minus any response this cycle.
- halt: only gates new requests; in-flight responses are still pushed or dropped.
- Invariant: outstanding + stale ≤ DEPTH.
  - Assertion: no fifo_add when fifo_num_entries==DEPTH.
  - Assertion: no mem_resp_valid when outstanding+stale==0.
- Mid-operation reset: immediate return to reset values. Responses to pre-reset requests are the memory's responsibility, since memory is reset alongside.

Decomposition:
- Shared package: prefetch state enum (RUN, DRAIN) and a PF_NE_BITS helper constant.
- One natural sub-module, credit_counter: up/down counter with load and underflow assertion. Instantiated twice, for outstanding and for stale.

Test Plan:
1. Back-to-back, DEPTH=3, memory always ready, 1-cycle latency, no consumer → exactly 3 requests to addresses 0, 1, 2. mem_req_valid stays low while num_entries=3. Queue holds words from 0, 1, 2.
2. Consumer removes one entry at a time from a full queue → exactly one new request per removal (addr 3, then 4). No overflow.
3. Redirect to 0x0100 with 2 outstanding → fifo_clear pulses once. The next 2 responses are dropped with fifo_add=0. The first push is data from 0x0100.
4. Redirect in the same cycle as a response and a ready memory → no fire that cycle; that response is not pushed; stale=outstanding−1. The next request addresses redirect_addr.
5. pc=0xFFFF with requests flowing → next request addresses 0x0000.
6. Async reset asserted mid-DRAIN with stale=2 → all outputs go to reset values immediately. After deassertion, the first request addresses 0 within 1 cycle.
